mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access pipeline stage that sits directly downstream of the execute stage and upstream of write-back.
- Latches execute-stage results into its own pipeline register.
- Waits for variable-latency data-SRAM read responses, then byte/halfword-extracts and sign/zero-extends load data.
- Presents write-back data and forwarding/hazard information to earlier stages, under the valid/allow_in pipeline handshake.

Parameters:
RESET_PC, 32'h1c000000, value of ms_pc after reset.

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
es_to_ms_valid  in  1  execute stage offers an instruction
ms_allow_in  out  1  this stage can accept this cycle
es_pc  in  32  instruction PC
es_rf_we  in  4  register-file write enable (nonzero = write)
es_rf_waddr  in  5  destination register
es_rf_wdata  in  32  ALU result; for loads, the effective address
es_load_op  in  3  000 none, 001 ld.b, 010 ld.h, 011 ld.w, 101 ld.bu, 110 ld.hu
data_sram_data_ok  in  1  read response valid (one-cycle pulse)
data_sram_rdata  in  32  read response word
ws_allow_in  in  1  write-back stage can accept
ms_to_ws_valid  out  1  valid && ready_go
ms_pc  out  32  registered PC
ms_rf_we  out  4  registered write enable, gated by ms_valid
ms_rf_waddr  out  5  registered destination
ms_rf_wdata  out  32  final write data (extended load value or ALU result)
ms_fwd_valid  out  1  ms_rf_wdata usable for forwarding this cycle
ms_load_pending  out  1  valid load whose data has not yet arrived (ID must stall on match)

Behaviour:
- Reset: ms_valid=0, state=IDLE, ms_pc=RESET_PC, all other registers 0; ms_to_ws_valid=0, ms_rf_we=0, ms_fwd_valid=0, ms_load_pending=0, ms_allow_in=1.
- Handshake: ms_allow_in = !ms_valid || (ms_ready_go && ws_allow_in).
  - On ms_allow_in: ms_valid <= es_to_ms_valid, and payload registers load from es_*.
  - Payload loads only when es_to_ms_valid=1; otherwise payload is held and ms_valid clears.
  - Accept and drain in the same cycle are allowed: back-to-back throughput 1/cycle for non-loads.
- ms_ready_go = !is_load || (state==WAIT && data_sram_data_ok) || state==HOLD.
- FSM, is_load = ms_valid && load_op!=000:
  - IDLE: accepting a load → WAIT. Accepting a non-load → stay IDLE.
  - WAIT: data_ok && ws_allow_in → drain. If a new load is accepted the same cycle, stay WAIT; otherwise → IDLE.
  - WAIT: data_ok && !ws_allow_in → capture data_sram_rdata into rdata_buf → HOLD.
  - WAIT: no data_ok → stay.
  - HOLD: ws_allow_in → drain; next state per the incoming instruction (load → WAIT, else IDLE). Otherwise stay, using rdata_buf.
  - data_ok outside WAIT is ignored. Exactly one response per load.
- Data selection: raw = (state==HOLD) ? rdata_buf : data_sram_rdata.
- Extraction uses addr[1:0] = registered es_rf_wdata[1:0]:
  - byte: raw[8*addr+7 : 8*addr].
  - halfword: addr[1] ? raw[31:16] : raw[15:0].
  - ld.b/ld.h sign-extend; ld.bu/ld.hu zero-extend; ld.w uses the full word.
- ms_rf_wdata = is_load ? extended : registered es_rf_wdata.
- ms_fwd_valid = ms_valid && ms_rf_we!=0 && ms_ready_go.
- ms_load_pending = is_load && !ms_ready_go.
- Reset mid-WAIT/HOLD: returns to IDLE. A response arriving after reset is ignored.

Optional Feature:
Macro MS_ALIGN_CHK_EN.
- Defined: a load with a misaligned address is treated as complete immediately, with no data_ok required:
  - ld.h/ld.hu misaligned when addr[0]=1.
  - ld.w misaligned when addr[1:0]!=0.
  - ms_rf_we is forced to 0.
  - Adds output ms_ale (1 bit) = ms_valid && misaligned, reset 0.
  - FSM does not enter WAIT for it, and data_ok is not expected for it.
- Undefined: no check, port ms_ale absent; address low bits are used as-is per the extraction rules.

Test Plan:
- Non-load ALU op, es_rf_wdata=32'h12345678, waddr=5, ws_allow_in=1 → next cycle ms_to_ws_valid=1, ms_rf_wdata=32'h12345678, ms_fwd_valid=1.
- ld.b addr ending 2'b11, data_ok after 3 cycles with rdata=32'h80FF_0000 → ms_load_pending=1 for 3 cycles, then ms_rf_wdata=32'hFFFF_FF80; ld.bu same case → 32'h0000_0080.
- ld.hu addr[1]=1, rdata=32'hBEEF_1234, data_ok with ws_allow_in=0 for 2 cycles → HOLD entered, ms_rf_wdata stable at 32'h0000_BEEF, ms_allow_in=0; drain when ws_allow_in rises.
- Back-to-back loads, each data_ok a single pulse, ws_allow_in=1 → state remains WAIT across the boundary; both results correct, no lost or duplicated response.
- Reset asserted in WAIT, then stray data_ok=1 → all outputs at reset values, ms_valid stays 0.
- With MS_ALIGN_CHK_EN defined, ld.w addr=32'h1000_0002 → ms_ale=1, ms_rf_we=0, completes without data_ok.

Source files
------------

// File: rtl/mem_stage.sv
// -----------------------------------------------------------------------------
// mem_stage : memory-access pipeline stage (between execute and write-back)
//
// Purpose
//   Latches execute-stage results and waits for the variable-latency data-SRAM
//   read response of a load. It then extracts the byte or halfword and extends
//   it to 32 bits. It hands the result to write-back under a valid/allow_in
//   handshake, and publishes forwarding and load-hazard information for the
//   decode stage.
//
// Ports
//   clk, reset          clock, synchronous active-high reset
//   es_to_ms_valid      execute stage offers an instruction
//   ms_allow_in         this stage can accept an instruction this cycle
//   es_pc/es_rf_we/es_rf_waddr/es_rf_wdata/es_load_op
//                       execute payload (es_rf_wdata is the address for loads)
//   data_sram_data_ok   one-cycle read response strobe
//   data_sram_rdata     read response word
//   ws_allow_in         write-back stage can accept
//   ms_to_ws_valid      result offered to write-back
//   ms_pc, ms_rf_we, ms_rf_waddr, ms_rf_wdata
//                       write-back payload
//   ms_fwd_valid        ms_rf_wdata may be forwarded this cycle
//   ms_load_pending     valid load still waiting for its data
//   ms_ale              (MS_ALIGN_CHK_EN only) misaligned load in this stage
//
// Configuration
//   `define MS_ALIGN_CHK_EN to enable misaligned-load detection. A misaligned
//   ld.h/ld.hu/ld.w then completes at once with its register write suppressed,
//   and it does not wait for a memory response.
//
// Load op encoding: 000 none, 001 ld.b, 010 ld.h, 011 ld.w, 101 ld.bu, 110 ld.hu
// -----------------------------------------------------------------------------
module mem_stage #(
    parameter logic [31:0] RESET_PC = 32'h1c00_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        es_to_ms_valid,
    output logic        ms_allow_in,
    input  logic [31:0] es_pc,
    input  logic [3:0]  es_rf_we,
    input  logic [4:0]  es_rf_waddr,
    input  logic [31:0] es_rf_wdata,
    input  logic [2:0]  es_load_op,
    input  logic        data_sram_data_ok,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allow_in,
    output logic        ms_to_ws_valid,
    output logic [31:0] ms_pc,
    output logic [3:0]  ms_rf_we,
    output logic [4:0]  ms_rf_waddr,
    output logic [31:0] ms_rf_wdata,
    output logic        ms_fwd_valid,
    output logic        ms_load_pending
`ifdef MS_ALIGN_CHK_EN
    ,
    output logic        ms_ale
`endif
);

    // IDLE: no outstanding response. WAIT: a response is due.
    // HOLD: the response arrived while write-back was stalled, so the word
    // is parked in rdata_buf_r.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t      state_r;
    logic        ms_valid_r;
    logic [31:0] pc_r;
    logic [3:0]  rf_we_r;
    logic [4:0]  rf_waddr_r;
    logic [31:0] alu_r;
    logic [2:0]  load_op_r;
    logic [31:0] rdata_buf_r;

    logic        is_load_s;
    logic        ale_s;
    logic        ready_go_s;
    logic        accept_s;
    logic        incoming_wait_s;
    logic [31:0] raw_s;
    logic [31:0] ext_s;
    logic [3:0]  rf_we_s;

    // Select the addressed byte/halfword and extend it according to the load type.
    function automatic logic [31:0] load_extend(input logic [2:0]  op,
                                                input logic [1:0]  addr,
                                                input logic [31:0] raw);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        case (addr)
            2'b00:   b = raw[7:0];
            2'b01:   b = raw[15:8];
            2'b10:   b = raw[23:16];
            2'b11:   b = raw[31:24];
            default: b = raw[7:0];
        endcase
        h = addr[1] ? raw[31:16] : raw[15:0];
        case (op)
            3'b001:  res = {{24{b[7]}}, b};
            3'b101:  res = {24'h00_0000, b};
            3'b010:  res = {{16{h[15]}}, h};
            3'b110:  res = {16'h0000, h};
            3'b011:  res = raw;
            default: res = raw;
        endcase
        return res;
    endfunction

`ifdef MS_ALIGN_CHK_EN
    // Halfword loads need addr[0]==0 and word loads need addr[1:0]==0.
    // Byte loads are always aligned.
    function automatic logic is_misaligned(input logic [2:0] op,
                                           input logic [1:0] addr);
        logic res;
        case (op)
            3'b010, 3'b110: res = addr[0];
            3'b011:         res = (addr != 2'b00);
            default:        res = 1'b0;
        endcase
        return res;
    endfunction
`endif

    // Handshake, completion and hazard terms derived from the pipeline register.
    always_comb begin
        is_load_s = ms_valid_r && (load_op_r != 3'b000);
`ifdef MS_ALIGN_CHK_EN
        ale_s = ms_valid_r && is_misaligned(load_op_r, alu_r[1:0]);
`else
        ale_s = 1'b0;
`endif
        // A misaligned load never issues a request, so it is done at once.
        ready_go_s = !is_load_s
                     || ((state_r == WAIT) && data_sram_data_ok)
                     || (state_r == HOLD)
                     || ale_s;
        ms_allow_in = !ms_valid_r || (ready_go_s && ws_allow_in);
        accept_s    = ms_allow_in && es_to_ms_valid;
        // The incoming instruction will wait for a response only if it is a
        // load that actually goes to memory.
`ifdef MS_ALIGN_CHK_EN
        incoming_wait_s = accept_s && (es_load_op != 3'b000)
                          && !is_misaligned(es_load_op, es_rf_wdata[1:0]);
`else
        incoming_wait_s = accept_s && (es_load_op != 3'b000);
`endif
    end

    // Load-data path: use the parked word while stalled in HOLD, else the live bus.
    always_comb begin
        if (state_r == HOLD) begin
            raw_s = rdata_buf_r;
        end else begin
            raw_s = data_sram_rdata;
        end
        ext_s = load_extend(load_op_r, alu_r[1:0], raw_s);
    end

    // Write enable is qualified by the valid bit and is killed for a misaligned load.
    always_comb begin
        if (ms_valid_r && !ale_s) begin
            rf_we_s = rf_we_r;
        end else begin
            rf_we_s = 4'h0;
        end
    end

    assign ms_to_ws_valid  = ms_valid_r && ready_go_s;
    assign ms_pc           = pc_r;
    assign ms_rf_we        = rf_we_s;
    assign ms_rf_waddr     = rf_waddr_r;
    assign ms_rf_wdata     = is_load_s ? ext_s : alu_r;
    assign ms_fwd_valid    = ms_valid_r && (rf_we_s != 4'h0) && ready_go_s;
    assign ms_load_pending = is_load_s && !ready_go_s;
`ifdef MS_ALIGN_CHK_EN
    assign ms_ale          = ale_s;
`endif

    // Pipeline register: valid bit and payload captured from the execute stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_r <= 1'b0;
            pc_r       <= RESET_PC;
            rf_we_r    <= 4'h0;
            rf_waddr_r <= 5'd0;
            alu_r      <= 32'h0000_0000;
            load_op_r  <= 3'b000;
        end else begin
            if (ms_allow_in) begin
                ms_valid_r <= es_to_ms_valid;
            end
            // Payload is held when nothing valid is offered.
            if (accept_s) begin
                pc_r       <= es_pc;
                rf_we_r    <= es_rf_we;
                rf_waddr_r <= es_rf_waddr;
                alu_r      <= es_rf_wdata;
                load_op_r  <= es_load_op;
            end
        end
    end

    // Response FSM: tracks the outstanding read and parks a response that
    // arrives while write-back is stalled. A data_ok outside WAIT is ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            rdata_buf_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                IDLE: begin
                    if (ms_allow_in) begin
                        state_r <= incoming_wait_s ? WAIT : IDLE;
                    end
                end
                WAIT: begin
                    if (data_sram_data_ok) begin
                        if (ws_allow_in) begin
                            // Drain now. A load accepted in the same cycle
                            // keeps the FSM in WAIT for its own response.
                            state_r <= incoming_wait_s ? WAIT : IDLE;
                        end else begin
                            rdata_buf_r <= data_sram_rdata;
                            state_r     <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (ws_allow_in) begin
                        state_r <= incoming_wait_s ? WAIT : IDLE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        es_to_ms_valid;
    logic        ms_allow_in;
    logic [31:0] es_pc;
    logic [3:0]  es_rf_we;
    logic [4:0]  es_rf_waddr;
    logic [31:0] es_rf_wdata;
    logic [2:0]  es_load_op;
    logic        data_sram_data_ok;
    logic [31:0] data_sram_rdata;
    logic        ws_allow_in;
    logic        ms_to_ws_valid;
    logic [31:0] ms_pc;
    logic [3:0]  ms_rf_we;
    logic [4:0]  ms_rf_waddr;
    logic [31:0] ms_rf_wdata;
    logic        ms_fwd_valid;
    logic        ms_load_pending;
`ifdef MS_ALIGN_CHK_EN
    logic        ms_ale;
`endif

    int checks;
    int failures;

    mem_stage #(.RESET_PC(32'h1c00_0000)) dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .ms_allow_in       (ms_allow_in),
        .es_pc             (es_pc),
        .es_rf_we          (es_rf_we),
        .es_rf_waddr       (es_rf_waddr),
        .es_rf_wdata       (es_rf_wdata),
        .es_load_op        (es_load_op),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .ws_allow_in       (ws_allow_in),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_pc             (ms_pc),
        .ms_rf_we          (ms_rf_we),
        .ms_rf_waddr       (ms_rf_waddr),
        .ms_rf_wdata       (ms_rf_wdata),
        .ms_fwd_valid      (ms_fwd_valid),
        .ms_load_pending   (ms_load_pending)
`ifdef MS_ALIGN_CHK_EN
        ,
        .ms_ale            (ms_ale)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] pc, input logic [4:0] waddr,
                         input logic [31:0] wdata, input logic [2:0] op);
        es_to_ms_valid = 1'b1;
        es_pc          = pc;
        es_rf_we       = 4'hf;
        es_rf_waddr    = waddr;
        es_rf_wdata    = wdata;
        es_load_op     = op;
    endtask

    initial begin
        checks = 0;
        failures = 0;
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        es_pc = 32'h0;
        es_rf_we = 4'h0;
        es_rf_waddr = 5'd0;
        es_rf_wdata = 32'h0;
        es_load_op = 3'b000;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h0;
        ws_allow_in = 1'b1;
        repeat (2) tick();
        reset = 1'b0;
        #1;
        // Reset state
        chk1("rst_to_ws", ms_to_ws_valid, 1'b0);
        chk1("rst_allow_in", ms_allow_in, 1'b1);
        chk("rst_pc", ms_pc, 32'h1c00_0000);
        chk("rst_we", {28'h0, ms_rf_we}, 32'h0);
        chk1("rst_fwd", ms_fwd_valid, 1'b0);
        chk1("rst_pending", ms_load_pending, 1'b0);

        // Non-load ALU result passes straight through
        offer(32'h1c00_0004, 5'd5, 32'h1234_5678, 3'b000);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("alu_to_ws", ms_to_ws_valid, 1'b1);
        chk("alu_wdata", ms_rf_wdata, 32'h1234_5678);
        chk1("alu_fwd", ms_fwd_valid, 1'b1);
        chk("alu_waddr", {27'h0, ms_rf_waddr}, 32'd5);
        chk("alu_pc", ms_pc, 32'h1c00_0004);

        // ld.b at address ...3, response after 3 cycles
        offer(32'h1c00_0008, 5'd6, 32'h1000_0003, 3'b001);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("ldb_allow_in", ms_allow_in, 1'b0);
        for (int i = 0; i < 3; i++) begin
            chk1("ldb_pending", ms_load_pending, 1'b1);
            chk1("ldb_to_ws_wait", ms_to_ws_valid, 1'b0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        #1;
        chk("ldb_wdata", ms_rf_wdata, 32'hFFFF_FF80);
        chk1("ldb_to_ws", ms_to_ws_valid, 1'b1);
        chk1("ldb_pending_done", ms_load_pending, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk1("ldb_drained", ms_to_ws_valid, 1'b0);

        // ld.bu, same address and data
        offer(32'h1c00_000c, 5'd6, 32'h1000_0003, 3'b101);
        tick();
        es_to_ms_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk1("ldbu_pending", ms_load_pending, 1'b1);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h80FF_0000;
        #1;
        chk("ldbu_wdata", ms_rf_wdata, 32'h0000_0080);
        tick();
        data_sram_data_ok = 1'b0;

        // ld.hu upper half, write-back stalled when the response arrives
        offer(32'h1c00_0010, 5'd7, 32'h1000_0002, 3'b110);
        tick();
        es_to_ms_valid = 1'b0;
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hBEEF_1234;
        ws_allow_in = 1'b0;
        #1;
        chk("ldhu_wdata_ok", ms_rf_wdata, 32'h0000_BEEF);
        chk1("ldhu_allow_in_ok", ms_allow_in, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'hDEAD_DEAD;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("ldhu_hold_wdata", ms_rf_wdata, 32'h0000_BEEF);
            chk1("ldhu_hold_allow_in", ms_allow_in, 1'b0);
            chk1("ldhu_hold_to_ws", ms_to_ws_valid, 1'b1);
            chk1("ldhu_hold_pending", ms_load_pending, 1'b0);
            tick();
        end
        ws_allow_in = 1'b1;
        #1;
        chk1("ldhu_release_allow_in", ms_allow_in, 1'b1);
        tick();
        chk1("ldhu_drained", ms_to_ws_valid, 1'b0);

        // Back-to-back loads: ld.w then ld.h, one pulse each
        offer(32'h1c00_0020, 5'd8, 32'h2000_0000, 3'b011);
        tick();
        offer(32'h1c00_0024, 5'd9, 32'h2000_0002, 3'b010);
        #1;
        chk1("b2b_a_pending", ms_load_pending, 1'b1);
        chk1("b2b_a_allow_in", ms_allow_in, 1'b0);
        tick();
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'hCAFE_F00D;
        #1;
        chk("b2b_a_wdata", ms_rf_wdata, 32'hCAFE_F00D);
        chk("b2b_a_waddr", {27'h0, ms_rf_waddr}, 32'd8);
        chk1("b2b_a_allow_in_ok", ms_allow_in, 1'b1);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_data_ok = 1'b0;
        data_sram_rdata = 32'h8001_7FFF;
        #1;
        chk1("b2b_b_pending", ms_load_pending, 1'b1);
        chk1("b2b_b_to_ws", ms_to_ws_valid, 1'b0);
        chk("b2b_b_waddr", {27'h0, ms_rf_waddr}, 32'd9);
        tick();
        data_sram_data_ok = 1'b1;
        #1;
        chk("b2b_b_wdata", ms_rf_wdata, 32'hFFFF_8001);
        chk1("b2b_b_to_ws_ok", ms_to_ws_valid, 1'b1);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk1("b2b_no_dup", ms_to_ws_valid, 1'b0);
        chk1("b2b_idle_pending", ms_load_pending, 1'b0);

        // Reset while waiting, followed by a stray response
        offer(32'h1c00_0030, 5'd10, 32'h3000_0000, 3'b011);
        tick();
        es_to_ms_valid = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata = 32'h5555_AAAA;
        #1;
        chk1("rw_to_ws", ms_to_ws_valid, 1'b0);
        chk1("rw_allow_in", ms_allow_in, 1'b1);
        chk("rw_pc", ms_pc, 32'h1c00_0000);
        chk("rw_we", {28'h0, ms_rf_we}, 32'h0);
        chk("rw_wdata", ms_rf_wdata, 32'h0);
        chk1("rw_pending", ms_load_pending, 1'b0);
        chk1("rw_fwd", ms_fwd_valid, 1'b0);
        tick();
        data_sram_data_ok = 1'b0;
        #1;
        chk1("rw_stays_invalid", ms_to_ws_valid, 1'b0);
        chk1("rw_no_pending", ms_load_pending, 1'b0);

`ifdef MS_ALIGN_CHK_EN
        // Misaligned ld.w completes immediately with the write suppressed
        offer(32'h1c00_0040, 5'd11, 32'h1000_0002, 3'b011);
        tick();
        es_to_ms_valid = 1'b0;
        #1;
        chk1("ale_flag", ms_ale, 1'b1);
        chk("ale_we", {28'h0, ms_rf_we}, 32'h0);
        chk1("ale_to_ws", ms_to_ws_valid, 1'b1);
        chk1("ale_pending", ms_load_pending, 1'b0);
        chk1("ale_fwd", ms_fwd_valid, 1'b0);
        tick();
        chk1("ale_cleared", ms_ale, 1'b0);
        chk1("ale_drained", ms_to_ws_valid, 1'b0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
